wb_burst_master: RTL and testbench
==================================

Name: wb_burst_master

Overview:
- Upstream Wishbone master that feeds the SDRAM controller's Wishbone slave port.
- Converts single-request commands (address, length, direction) from a local client into Wishbone incrementing bursts (cti 010/111).
- Streams write data in and read data out.
- Holds off all commands until the controller reports SDRAM initialisation complete.

Parameters:
- APP_AW, 26, Wishbone byte-address width.
- dw, 32, Wishbone data width (multiple of 8).
- LEN_W, 8, command length field width; a burst is up to 2^LEN_W words.
- TIMEOUT_CYC, 255, ack-wait limit in cycles (used only with the optional feature).

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- sdr_init_done  in  1  SDRAM init complete (level).
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  APP_AW  start byte address; low log2(dw/8) bits are ignored (forced 0).
- cmd_len  in  LEN_W  number of words minus 1.
- wr_data  in  dw  write data.
- wr_valid  in  1  write data available.
- wr_ready  out  1  write word consumed when wr_valid and wr_ready are both high.
- rd_data  out  dw  read data.
- rd_valid  out  1  one-cycle qualifier per read word; no backpressure.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone control.
- wb_cti_o  out  3  cycle type.
- wb_sel_o  out  dw/8  byte selects; always all ones.
- wb_addr_o  out  APP_AW  byte address.
- wb_dat_o  out  dw  write data.
- wb_dat_i  in  dw  read data.
- wb_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset (asynchronous, immediate, including mid-burst):
  - state = IDLE.
  - All outputs 0, except wb_sel_o = all ones.
  - No done pulse is produced for an aborted command.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - cmd_ready = sdr_init_done.
  - On accept, latch addr, len and we into registers, then go to RD or WR.
  - wb_cyc_o rises the cycle after accept.
  - busy = (state != IDLE).
- Beat counter:
  - Loaded with cmd_len; decrements on each wb_ack_i while wb_stb_o is high.
  - The last beat is the one where counter == 0.
- Address:
  - wb_addr_o starts at the latched address.
  - Adds dw/8 on every acked beat, wrapping modulo 2^APP_AW.
- wb_cti_o:
  - 3'b010 while counter != 0.
  - 3'b111 on the last beat, including single-word commands (cmd_len = 0).
- RD:
  - wb_cyc_o = wb_stb_o = 1, wb_we_o = 0.
  - Each ack registers wb_dat_i into rd_data with rd_valid = 1 on the following cycle (latency 1).
  - The ack of the last beat goes to DONE; wb_cyc_o and wb_stb_o drop in the same edge.
- WR:
  - One-word holding register feeds wb_dat_o.
  - wr_ready = 1 when the register is empty, or when it is acked this cycle and counter != 0.
  - wb_stb_o = register full; wb_we_o = 1.
  - If wr_valid is low, stb drops while cyc stays high (master wait state) and cti holds 010.
  - No more than cmd_len+1 words are consumed.
  - The ack of the last beat goes to DONE.
- DONE: done = 1 for one cycle, then IDLE. A new command can be accepted the cycle after DONE.
- Slave stall: stb, addr, dat and cti are held stable until ack.
- wb_ack_i while wb_stb_o is low is ignored.
- sdr_init_done falling while busy: the current command completes; new commands are blocked.

Optional Feature:
- Macro: WB_BURST_MASTER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while wb_stb_o is high and wb_ack_i is low; it clears on ack.
  - If it reaches TIMEOUT_CYC: drop cyc and stb, pulse the extra output port err (1 bit) with done in the same cycle, discard remaining beats, return to IDLE via DONE.
  - Unconsumed write data in the holding register is dropped.
- Not defined: no counter, no err port; the master waits for ack indefinitely.

Test Plan:
- Reset with sdr_init_done = 0 and cmd_valid = 1 -> cmd_ready stays 0 and cyc stays 0; sdr_init_done = 1 -> accept next cycle, cyc rises one cycle later.
- Write addr 0x0000100, len 3, data 0xA0..0xA3, slave acks every cycle -> addrs 0x100/0x104/0x108/0x10C; cti 010,010,010,111; done pulses once after the 4th ack.
- Read addr 0x3FFFFF8, len 3, slave inserts 2 wait states per beat -> addrs 0x3FFFFF8, 0x3FFFFFC, 0x0000000, 0x0000004 (wrap); four rd_valid pulses each 1 cycle after ack, matching slave data.
- Write len 0 -> single beat with cti 111, one wr_ready handshake, done 1 cycle after ack.
- Write len 7 with wr_valid low for 5 cycles after beat 2 -> stb low and cyc high during the gap; 8 beats total with data in order.
- Assert wb_rst_i mid-read at beat 2 -> cyc, stb and busy go 0 immediately; no done; the next command starts cleanly.

Source files
------------

// File: rtl/wb_burst_master.sv
// Wishbone incrementing-burst master: turns (addr, len, we) commands into cti 010/111 bursts.
// Optional ack-wait timeout with err output when WB_BURST_MASTER_TIMEOUT_EN is defined.
module wb_burst_master #(
  parameter int unsigned APP_AW      = 26,
  parameter int unsigned dw          = 32,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              sys_clk,
  input  logic              wb_rst_i,
  input  logic              sdr_init_done,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [dw-1:0]     wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [dw-1:0]     rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
`ifdef WB_BURST_MASTER_TIMEOUT_EN
  output logic              err,
`endif
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [2:0]        wb_cti_o,
  output logic [dw/8-1:0]   wb_sel_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  input  logic [dw-1:0]     wb_dat_i,
  input  logic              wb_ack_i
);

  localparam int unsigned        BPW       = dw / 8;
  localparam logic [APP_AW-1:0]  ADDR_STEP = APP_AW'(BPW);
  localparam logic [APP_AW-1:0]  ADDR_MASK = APP_AW'(BPW - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [APP_AW-1:0]   addr_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [dw-1:0]       hold_q;
  logic                hold_full;
  logic [dw-1:0]       rd_data_q;
  logic                rd_valid_q;
  logic                accept;
  logic                beat_ack;
  logic                last_beat;
  logic                timeout_hit;

  assign last_beat = (cnt_q == '0);
  assign accept    = cmd_valid && cmd_ready;
  assign beat_ack  = wb_stb_o && wb_ack_i;

  assign wb_sel_o  = '1;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = hold_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge sys_clk or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    done      = 1'b0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_cti_o  = 3'b000;
    case (state)
      S_IDLE: begin
        // Gated by reset so every output reads 0 while reset is held.
        cmd_ready = sdr_init_done && !wb_rst_i;
        if (cmd_valid && cmd_ready) state_nxt = cmd_we ? S_WR : S_RD;
      end
      S_RD: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_cti_o = last_beat ? 3'b111 : 3'b010;
        if (wb_ack_i && last_beat) state_nxt = S_DONE;
      end
      S_WR: begin
        wb_cyc_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_stb_o = hold_full;
        // A master wait state keeps cti at 010 even before the last word.
        wb_cti_o = (hold_full && last_beat) ? 3'b111 : 3'b010;
        wr_ready = !hold_full || (wb_ack_i && !last_beat);
        if (hold_full && wb_ack_i && last_beat) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (timeout_hit) state_nxt = S_DONE;
  end

  always_ff @(posedge sys_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      hold_full  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (state == S_IDLE) begin
        if (accept) begin
          addr_q    <= cmd_addr & ~ADDR_MASK;
          cnt_q     <= cmd_len;
          hold_full <= 1'b0;
        end
      end else begin
        if (beat_ack) begin
          addr_q <= addr_q + ADDR_STEP;
          if (!last_beat) cnt_q <= cnt_q - LEN_W'(1);
        end
        if (state == S_RD && beat_ack) begin
          rd_data_q  <= wb_dat_i;
          rd_valid_q <= 1'b1;
        end
        if (state == S_WR) begin
          if (wr_valid && wr_ready) begin
            hold_q    <= wr_data;
            hold_full <= 1'b1;
          end else if (beat_ack) begin
            hold_full <= 1'b0;
          end
        end
        if (timeout_hit) hold_full <= 1'b0;
      end
    end
  end

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] to_cnt;
  logic          err_q;

  // Fires on the stall cycle whose edge would bring the count to TIMEOUT_CYC.
  assign timeout_hit = wb_stb_o && !wb_ack_i && (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign err         = err_q;

  always_ff @(posedge sys_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (timeout_hit || accept || beat_ack) to_cnt <= '0;
      else if (wb_stb_o)                     to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed + randomized bench for wb_burst_master with a Wishbone slave model and
// a burst-level reference (expected address/cti/data per beat computed arithmetically).
module tb_wb_burst_master;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;

  logic          sys_clk = 1'b0;
  logic          wb_rst_i, sdr_init_done, cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data, rd_data, wb_dat_o, wb_dat_i;
  logic          wr_valid, wr_ready, rd_valid, busy, done;
  logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [2:0]    wb_cti_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [AW-1:0] wb_addr_o;

  wb_burst_master #(.APP_AW(AW), .dw(DW), .LEN_W(LW), .TIMEOUT_CYC(255)) dut (
    .sys_clk(sys_clk), .wb_rst_i(wb_rst_i), .sdr_init_done(sdr_init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_cti_o(wb_cti_o), .wb_sel_o(wb_sel_o), .wb_addr_o(wb_addr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Slave / feeder configuration and observations
  int unsigned   ws, wcnt, gap_at, gap_left, wr_idx, wr_hs;
  int unsigned   viol, n_wait, done_cnt, done_cyc, last_beat_cyc, cyc_n;
  bit            spurious, prev_stall, prev_ack_rd;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_dat;
  logic [2:0]    s_cti;
  logic [DW-1:0] rd_seed;
  logic [DW-1:0] wr_q[$];
  logic [AW-1:0] b_addr[$];
  logic [2:0]    b_cti[$];
  logic          b_we[$];
  logic [DW-1:0] b_dat[$];
  logic [DW-1:0] rd_got[$];

  // Reference expectations for the command in flight
  bit            e_we;
  logic [AW-1:0] e_base;
  int unsigned   e_len, e_gap;

  function automatic logic [DW-1:0] slave_word(input logic [AW-1:0] a);
    return {a, 6'b0} ^ rd_seed;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wishbone slave + write-data source, acting mid-cycle between rising edges
  initial begin
    wb_ack_i = 1'b0; wb_dat_i = '0; wr_valid = 1'b0; wr_data = '0;
    cyc_n = 0; prev_stall = 0; prev_ack_rd = 0;
    forever begin
      @(negedge sys_clk); #1;
      cyc_n++;
      if (wb_rst_i) begin
        wb_ack_i = 1'b0; wcnt = 0; prev_stall = 0; prev_ack_rd = 0; wr_valid = 1'b0;
      end else begin
        if (rd_valid !== prev_ack_rd) viol++;
        if (rd_valid) rd_got.push_back(rd_data);
        if (done) begin done_cnt++; done_cyc = cyc_n; end
        if (prev_stall && (!wb_stb_o || wb_addr_o !== s_addr || wb_cti_o !== s_cti ||
                           (wb_we_o && wb_dat_o !== s_dat))) viol++;
        if (wb_cyc_o && !wb_stb_o) begin
          n_wait++;
          if (wb_cti_o !== 3'b010) viol++;
        end
        prev_ack_rd = 0; prev_stall = 0; wb_ack_i = 1'b0;
        if (wb_stb_o) begin
          if (wcnt >= ws) begin
            wcnt = 0; wb_ack_i = 1'b1;
            wb_dat_i = wb_we_o ? $urandom : slave_word(wb_addr_o);
            b_addr.push_back(wb_addr_o); b_cti.push_back(wb_cti_o);
            b_we.push_back(wb_we_o); b_dat.push_back(wb_dat_o);
            last_beat_cyc = cyc_n; prev_ack_rd = !wb_we_o;
          end else begin
            wcnt++; prev_stall = 1;
            s_addr = wb_addr_o; s_dat = wb_dat_o; s_cti = wb_cti_o;
            wb_dat_i = $urandom;
          end
        end else if (wb_cyc_o && spurious) begin
          wb_ack_i = 1'b1;
        end
        if (wr_idx < wr_q.size()) begin
          if (wr_idx == gap_at && gap_left > 0) begin wr_valid = 1'b0; gap_left--; end
          else begin wr_valid = 1'b1; wr_data = wr_q[wr_idx]; end
        end else begin
          wr_valid = 1'b1; wr_data = 32'hDEAD_0000 | wr_hs;
        end
        #1;
        if (wr_valid && wr_ready) begin
          wr_hs++;
          if (wr_idx < wr_q.size()) wr_idx++;
        end
      end
    end
  end

  task automatic setup(input bit we, input logic [AW-1:0] a, input int unsigned len,
                       input int unsigned w, input int unsigned g_at,
                       input int unsigned g_len, input bit spur);
    e_we = we; e_base = a & 26'h3FF_FFFC; e_len = len;
    e_gap = (we && g_at <= len) ? g_len : 0;
    cmd_we = we; cmd_addr = a; cmd_len = LW'(len);
    ws = w; gap_at = g_at; gap_left = g_len; spurious = spur; wcnt = 0;
    b_addr.delete(); b_cti.delete(); b_we.delete(); b_dat.delete();
    rd_got.delete(); wr_q.delete();
    for (int i = 0; i <= int'(len); i++) wr_q.push_back($urandom);
    wr_idx = 0; wr_hs = 0; viol = 0; n_wait = 0; done_cnt = 0;
    rd_seed = $urandom;
  endtask

  task automatic issue(output bit ok);
    ok = 0;
    @(negedge sys_clk); cmd_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #3;
      if (cmd_ready) begin ok = 1; break; end
      @(negedge sys_clk);
    end
    @(negedge sys_clk); cmd_valid = 1'b0;
  endtask

  task automatic wait_check(input string tag);
    longint unsigned ea;
    for (int k = 0; k < 4000 && done_cnt == 0; k++) @(negedge sys_clk);
    repeat (4) @(negedge sys_clk);
    #3;
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_beats"}, b_addr.size(), e_len + 1);
    for (int i = 0; i <= int'(e_len) && i < b_addr.size(); i++) begin
      ea = (longint'(e_base) + 4 * i) % (64'd1 << AW);
      check($sformatf("%s_addr%0d", tag, i), b_addr[i], ea);
      check($sformatf("%s_cti%0d", tag, i), b_cti[i], (i == int'(e_len)) ? 3'b111 : 3'b010);
      check($sformatf("%s_we%0d", tag, i), b_we[i], e_we);
      if (e_we) check($sformatf("%s_wdat%0d", tag, i), b_dat[i], wr_q[i]);
      else if (i < rd_got.size())
        check($sformatf("%s_rdat%0d", tag, i), rd_got[i], slave_word(AW'(ea)));
    end
    check({tag, "_rd_words"}, rd_got.size(), e_we ? 0 : e_len + 1);
    check({tag, "_wr_words"}, wr_hs, e_we ? e_len + 1 : 0);
    if (done_cnt > 0) check({tag, "_done_latency"}, done_cyc - last_beat_cyc, 1);
    check({tag, "_protocol"}, viol, 0);
    check({tag, "_wait_states"}, n_wait, e_we ? 1 + e_gap : 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    bit ok;
    wb_rst_i = 1'b1; sdr_init_done = 1'b0; cmd_valid = 1'b1;
    setup(0, AW'($urandom), 1, 0, 999, 0, 0);

    // Reset values and init hold-off
    repeat (3) @(negedge sys_clk);
    #3;
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_cti", wb_cti_o, 0);
    check("rst_addr", wb_addr_o, 0);
    check("rst_sel", wb_sel_o, 4'hF);
    check("rst_rd_valid", rd_valid, 0);
    @(negedge sys_clk); wb_rst_i = 1'b0;
    repeat (3) begin
      @(negedge sys_clk); #3;
      check("noinit_cmd_ready", cmd_ready, 0);
      check("noinit_cyc", wb_cyc_o, 0);
    end
    @(negedge sys_clk); sdr_init_done = 1'b1; #3;
    check("init_cmd_ready", cmd_ready, 1);
    check("init_cyc_before", wb_cyc_o, 0);
    @(negedge sys_clk); cmd_valid = 1'b0; #3;
    check("init_cyc_after", wb_cyc_o, 1);
    check("init_busy", busy, 1);
    wait_check("first_rd");

    // Write 0x100, len 3, data A0..A3, no stalls
    setup(1, 26'h000_0100, 3, 0, 999, 0, 0);
    for (int i = 0; i < 4; i++) wr_q[i] = 32'hA0 + i;
    issue(ok); check("wr4_accept", ok, 1);
    wait_check("wr4");

    // Read across the top of the address space with 2 wait states per beat
    setup(0, 26'h3FF_FFF8, 3, 2, 999, 0, 0);
    issue(ok); check("rdwrap_accept", ok, 1);
    wait_check("rdwrap");

    // Single-word write
    setup(1, AW'($urandom), 0, 1, 999, 0, 0);
    issue(ok); check("wr1_accept", ok, 1);
    wait_check("wr1");

    // Write len 7, source idle 5 cycles after beat 2, stray acks while stb is low
    setup(1, AW'($urandom), 7, 0, 3, 5, 1);
    issue(ok); check("wrgap_accept", ok, 1);
    wait_check("wrgap");

    // Reset while waiting on beat 2 of a read
    setup(0, AW'($urandom), 3, 2, 999, 0, 0);
    issue(ok); check("rstmid_accept", ok, 1);
    for (int k = 0; k < 200 && b_addr.size() < 2; k++) begin @(negedge sys_clk); #3; end
    check("rstmid_reach_beat2", b_addr.size(), 2);
    @(negedge sys_clk); wb_rst_i = 1'b1; #3;
    check("rstmid_cyc", wb_cyc_o, 0);
    check("rstmid_stb", wb_stb_o, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    @(negedge sys_clk); wb_rst_i = 1'b0;
    repeat (4) @(negedge sys_clk);
    #3;
    check("rstmid_no_done", done_cnt, 0);
    setup(0, AW'($urandom), 2, 1, 999, 0, 0);
    issue(ok); check("after_rst_accept", ok, 1);
    wait_check("after_rst");

    // sdr_init_done drops mid-command: command completes, new ones blocked
    setup(1, AW'($urandom), 2, 1, 999, 0, 0);
    issue(ok); check("initdrop_accept", ok, 1);
    sdr_init_done = 1'b0;
    wait_check("initdrop");
    cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge sys_clk); #3;
      check("initdrop_blocked", cmd_ready, 0);
      check("initdrop_cyc", wb_cyc_o, 0);
    end
    cmd_valid = 1'b0; sdr_init_done = 1'b1;

    // Randomized commands
    for (int t = 0; t < 6; t++) begin
      setup(1'($urandom), AW'($urandom), $urandom_range(15, 0), $urandom_range(2, 0), 999, 0, 0);
      issue(ok); check($sformatf("rnd%0d_accept", t), ok, 1);
      wait_check($sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
